// File: rtl/enc_pkg.sv
// enc_pkg: shared helpers for the priority encoder family.
//   MAX_N         - largest supported request vector width
//   clog2_f       - ceil(log2(n)), used to size index ports
//   onehot_to_bin - binary index of a one-hot vector (OR of set positions)
//   popcount_ge2  - true when two or more bits of a vector are set
package enc_pkg;

  localparam int MAX_N = 64;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i <= 7; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Valid only for one-hot or zero input; zero maps to index 0.
  function automatic int onehot_to_bin(input logic [MAX_N-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) r = r | i;
    end
    return r;
  endfunction

  // Clearing the lowest set bit leaves something only if a second bit exists.
  function automatic logic popcount_ge2(input logic [MAX_N-1:0] v);
    return |(v & (v - MAX_N'(1)));
  endfunction

endpackage

// File: rtl/prio_pick.sv
// prio_pick: combinational first-set-bit search starting at a pointer.
//   req    [N-1:0] - request vector
//   start  [W-1:0] - search start position (must be < N)
//   onehot [N-1:0] - one-hot of the winning line, 0 when req == 0
//   idx    [W-1:0] - binary index of the winning line, 0 when req == 0
//   any            - at least one request is set
// Search order is start, start+1, ..., N-1, 0, ..., start-1.
module prio_pick
  import enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2_f(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // The request vector is laid out twice so a wrapped search becomes a plain
  // lowest-bit search: masking off positions below start leaves the upper copy
  // to supply the wrapped-around lines.
  always_comb begin
    dbl    = {req, req};
    masked = dbl & ({(2*N){1'b1}} << start);
    first  = masked & (~masked + (2*N)'(1));
    onehot = first[N-1:0] | first[2*N-1:N];
    idx    = W'(onehot_to_bin(MAX_N'(onehot)));
    any    = |req;
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: N-to-log2(N) priority encoder with a registered result.
//   clk, rst_n        - clock, asynchronous active-low reset
//   in_valid, in_req  - request vector and its qualifier
//   in_ready          - block can accept in_req this cycle
//   out_valid         - out_idx/out_onehot/out_multi hold a result
//   out_ready         - downstream consumes the result this cycle
//   out_idx           - binary index of the winning line
//   out_onehot        - one-hot of the winning line
//   out_multi         - accepted request had two or more bits set
//   dbg_ptr           - current round-robin pointer (always 0 in fixed mode)
// RR_MODE=0: lowest index wins. RR_MODE=1: search starts at a rotating pointer
// that moves to one past the last winner, wrapping at N.
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter int N       = 8,
  parameter int W       = clog2_f(N),
  parameter bit RR_MODE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in_req,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_multi,
  output logic [W-1:0] dbg_ptr
);

  // Handshake: a transfer happens on a side only in a cycle where its valid
  // and ready are both high. in_ready depends only on the output register
  // state and out_ready, never on in_valid. Once out_valid rises the result
  // holds unchanged until the cycle out_ready is seen high.

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic [N-1:0] out_onehot_q, out_onehot_d;
  logic         out_multi_q, out_multi_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [W-1:0] pick_start;
  logic [N-1:0] pick_onehot;
  logic [W-1:0] pick_idx;
  logic         pick_any;
  logic         accept;
  logic         accept_nz;
  logic         pop;

  assign pick_start = RR_MODE ? ptr_q : '0;

  prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .req    (in_req),
    .start  (pick_start),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Single output register: free when empty or being drained this cycle.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign accept_nz = accept && pick_any;
  assign pop       = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    out_multi_d  = out_multi_q;
    ptr_d        = ptr_q;
    if (accept_nz) begin
      out_valid_d  = 1'b1;
      out_idx_d    = pick_idx;
      out_onehot_d = pick_onehot;
      out_multi_d  = popcount_ge2(MAX_N'(in_req));
      if (RR_MODE) begin
        // Wrap at N, which need not be a power of two.
        ptr_d = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);
      end
    end else if (pop) begin
      // An all-zero accept in the same cycle produces nothing to replace it.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      out_multi_q  <= 1'b0;
      ptr_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      out_multi_q  <= out_multi_d;
      ptr_q        <= ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;
  assign out_multi  = out_multi_q;
  assign dbg_ptr    = ptr_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: three encoders share one input stream:
//   a = N=8 fixed priority, b = N=8 round-robin, c = N=5 round-robin (in_req[4:0]).
module tb_prio_encoder_rr;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_req;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_multi;
  logic [2:0] a_out_idx, a_dbg_ptr;
  logic [7:0] a_out_onehot;
  logic       b_in_ready, b_out_valid, b_out_multi;
  logic [2:0] b_out_idx, b_dbg_ptr;
  logic [7:0] b_out_onehot;
  logic       c_in_ready, c_out_valid, c_out_multi;
  logic [2:0] c_out_idx, c_dbg_ptr;
  logic [4:0] c_out_onehot;

  int checks;
  int failures;

  prio_encoder_rr #(.N(8), .RR_MODE(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_req(in_req),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_idx(a_out_idx), .out_onehot(a_out_onehot), .out_multi(a_out_multi),
    .dbg_ptr(a_dbg_ptr)
  );

  prio_encoder_rr #(.N(8), .RR_MODE(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_req(in_req),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_idx(b_out_idx), .out_onehot(b_out_onehot), .out_multi(b_out_multi),
    .dbg_ptr(b_dbg_ptr)
  );

  prio_encoder_rr #(.N(5), .RR_MODE(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_req(in_req[4:0]),
    .in_ready(c_in_ready), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_idx(c_out_idx), .out_onehot(c_out_onehot), .out_multi(c_out_multi),
    .dbg_ptr(c_dbg_ptr)
  );

  // Uniform views of the three instances for the randomized scenario.
  logic       obs_rdy[3];
  logic       obs_vld[3];
  logic       obs_mul[3];
  logic [2:0] obs_idx[3];
  logic [2:0] obs_ptr[3];
  logic [7:0] obs_oh[3];

  assign obs_rdy[0] = a_in_ready;  assign obs_rdy[1] = b_in_ready;  assign obs_rdy[2] = c_in_ready;
  assign obs_vld[0] = a_out_valid; assign obs_vld[1] = b_out_valid; assign obs_vld[2] = c_out_valid;
  assign obs_mul[0] = a_out_multi; assign obs_mul[1] = b_out_multi; assign obs_mul[2] = c_out_multi;
  assign obs_idx[0] = a_out_idx;   assign obs_idx[1] = b_out_idx;   assign obs_idx[2] = c_out_idx;
  assign obs_ptr[0] = a_dbg_ptr;   assign obs_ptr[1] = b_dbg_ptr;   assign obs_ptr[2] = c_dbg_ptr;
  assign obs_oh[0]  = a_out_onehot;
  assign obs_oh[1]  = b_out_onehot;
  assign obs_oh[2]  = {3'b000, c_out_onehot};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_req    = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [7:0] r, input logic rdy);
    in_valid  = v;
    in_req    = r;
    out_ready = rdy;
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    checks++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got a=%b b=%b c=%b exp 0", a_out_valid, b_out_valid, c_out_valid);
    end
    checks++;
    if (b_out_idx !== 3'd0 || b_out_onehot !== 8'h00 || b_out_multi !== 1'b0 || b_dbg_ptr !== 3'd0) begin
      failures++;
      $display("FAIL reset_regs got idx=%0d oh=%h multi=%b ptr=%0d exp all 0",
               b_out_idx, b_out_onehot, b_out_multi, b_dbg_ptr);
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", a_in_ready);
    end
  endtask

  task automatic test_walking_one();
    logic [7:0] r;
    for (int k = 0; k < 8; k++) begin
      r = 8'h01 << k;
      drive(1'b1, r, 1'b1);
      #1;
      checks++;
      if (a_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL walk_in_ready k=%0d got=%b exp=1", k, a_in_ready);
      end
      step();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_idx !== 3'(k) || a_out_onehot !== r || a_out_multi !== 1'b0) begin
        failures++;
        $display("FAIL walk k=%0d got v=%b idx=%0d oh=%h m=%b exp v=1 idx=%0d oh=%h m=0",
                 k, a_out_valid, a_out_idx, a_out_onehot, a_out_multi, k, r);
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    step();
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL walk_drain got v=%b exp=0", a_out_valid);
    end
  endtask

  task automatic test_multi_and_zero();
    drive(1'b1, 8'b1011_0100, 1'b1);
    step();
    checks++;
    if (a_out_valid !== 1'b1 || a_out_idx !== 3'd2 || a_out_onehot !== 8'b0000_0100 || a_out_multi !== 1'b1) begin
      failures++;
      $display("FAIL fixed_multi got v=%b idx=%0d oh=%h m=%b exp v=1 idx=2 oh=04 m=1",
               a_out_valid, a_out_idx, a_out_onehot, a_out_multi);
    end
    drive(1'b1, 8'h00, 1'b1);
    step();
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_accept got v=%b exp=0", a_out_valid);
    end
    step();
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_accept_hold got v=%b exp=0", a_out_valid);
    end
  endtask

  task automatic test_rr_sequence();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'hFF, 1'b1);
      step();
      checks++;
      if (b_out_valid !== 1'b1 || b_out_idx !== 3'(k % 8) || b_out_multi !== 1'b1) begin
        failures++;
        $display("FAIL rr_ff k=%0d got v=%b idx=%0d m=%b exp v=1 idx=%0d m=1",
                 k, b_out_valid, b_out_idx, b_out_multi, k % 8);
      end
    end
    checks++;
    if (b_dbg_ptr !== 3'd2) begin
      failures++;
      $display("FAIL rr_ptr_after_ff got=%0d exp=2", b_dbg_ptr);
    end
    drive(1'b1, 8'b0001_0001, 1'b1);
    step();
    checks++;
    if (b_out_idx !== 3'd4 || b_out_onehot !== 8'h10) begin
      failures++;
      $display("FAIL rr_11_first got idx=%0d oh=%h exp idx=4 oh=10", b_out_idx, b_out_onehot);
    end
    step();
    checks++;
    if (b_out_idx !== 3'd0 || b_out_onehot !== 8'h01) begin
      failures++;
      $display("FAIL rr_11_second got idx=%0d oh=%h exp idx=0 oh=01", b_out_idx, b_out_onehot);
    end
    drive(1'b0, 8'h00, 1'b1);
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 8'b0000_1000, 1'b1);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'hFF, 1'b0);
      #1;
      checks++;
      if (b_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_in_ready k=%0d got=%b exp=0", k, b_in_ready);
      end
      step();
      checks++;
      if (b_out_valid !== 1'b1 || b_out_idx !== 3'd3 || b_out_onehot !== 8'h08 ||
          b_out_multi !== 1'b0 || b_dbg_ptr !== 3'd4) begin
        failures++;
        $display("FAIL bp_hold k=%0d got v=%b idx=%0d oh=%h m=%b ptr=%0d exp v=1 idx=3 oh=08 m=0 ptr=4",
                 k, b_out_valid, b_out_idx, b_out_onehot, b_out_multi, b_dbg_ptr);
      end
    end
    drive(1'b1, 8'hFF, 1'b1);
    #1;
    checks++;
    if (b_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready got=%b exp=1", b_in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (b_out_valid !== 1'b1 || b_out_idx !== 3'(4 + k)) begin
        failures++;
        $display("FAIL bp_b2b k=%0d got v=%b idx=%0d exp v=1 idx=%0d", k, b_out_valid, b_out_idx, 4 + k);
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    step();
    checks++;
    if (b_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got v=%b exp=0", b_out_valid);
    end
  endtask

  task automatic test_rr_n5_wrap();
    logic [2:0] exp_idx[3];
    exp_idx = '{3'd0, 3'd4, 3'd0};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'b0001_0001, 1'b1);
      step();
      checks++;
      if (c_out_valid !== 1'b1 || c_out_idx !== exp_idx[k] || c_out_idx >= 3'd5) begin
        failures++;
        $display("FAIL n5_wrap k=%0d got v=%b idx=%0d exp v=1 idx=%0d", k, c_out_valid, c_out_idx, exp_idx[k]);
      end
      if (k == 1) begin
        checks++;
        if (c_dbg_ptr !== 3'd0) begin
          failures++;
          $display("FAIL n5_ptr_wrap got=%0d exp=0", c_dbg_ptr);
        end
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h0C, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    step();
    checks++;
    if (b_out_valid !== 1'b1 || b_dbg_ptr === 3'd0) begin
      failures++;
      $display("FAIL mid_pre got v=%b ptr=%0d exp v=1 ptr!=0", b_out_valid, b_dbg_ptr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b_out_valid !== 1'b0 || b_dbg_ptr !== 3'd0 || a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got bv=%b ptr=%0d av=%b exp 0 0 0", b_out_valid, b_dbg_ptr, a_out_valid);
    end
    #1;
    rst_n = 1'b1;
    step();
    drive(1'b1, 8'b1000_0001, 1'b1);
    step();
    checks++;
    if (b_out_valid !== 1'b1 || b_out_idx !== 3'd0) begin
      failures++;
      $display("FAIL mid_after got v=%b idx=%0d exp v=1 idx=0", b_out_valid, b_out_idx);
    end
    drive(1'b0, 8'h00, 1'b1);
    step();
  endtask

  // Reference model: result register and pointer per instance, updated by
  // scanning request lines in priority order with modular arithmetic.
  task automatic test_random();
    int         mn[3];
    bit         mrr[3];
    logic       m_vld[3];
    logic       m_mul[3];
    logic [2:0] m_idx[3];
    logic [2:0] m_ptr[3];
    logic [7:0] m_oh[3];
    logic [7:0] r;
    logic       v, rdy, exp_rdy;
    int         win, start, pos;
    logic [7:0] req_i;

    mn  = '{8, 8, 5};
    mrr = '{1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      m_vld[i] = 1'b0; m_mul[i] = 1'b0; m_idx[i] = '0; m_ptr[i] = '0; m_oh[i] = '0;
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      rdy = ($urandom_range(0, 3) != 0);
      drive(v, r, rdy);
      #1;
      for (int i = 0; i < 3; i++) begin
        exp_rdy = !m_vld[i] || rdy;
        checks++;
        if (obs_rdy[i] !== exp_rdy) begin
          failures++;
          $display("FAIL rand_in_ready inst=%0d cyc=%0d got=%b exp=%b", i, cyc, obs_rdy[i], exp_rdy);
        end
        req_i = (mn[i] == 8) ? r : (r & 8'h1F);
        if (v && exp_rdy && req_i != 0) begin
          start = mrr[i] ? int'(m_ptr[i]) : 0;
          win   = -1;
          for (int s = 0; s < mn[i]; s++) begin
            pos = (start + s) % mn[i];
            if (win < 0 && req_i[pos]) win = pos;
          end
          m_vld[i] = 1'b1;
          m_idx[i] = 3'(win);
          m_oh[i]  = 8'h01 << win;
          m_mul[i] = ($countones(req_i) >= 2);
          if (mrr[i]) m_ptr[i] = 3'((win + 1) % mn[i]);
        end else if (m_vld[i] && rdy) begin
          m_vld[i] = 1'b0;
        end
      end
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_vld[i] !== m_vld[i] || obs_ptr[i] !== m_ptr[i]) begin
          failures++;
          $display("FAIL rand_state inst=%0d cyc=%0d got v=%b ptr=%0d exp v=%b ptr=%0d",
                   i, cyc, obs_vld[i], obs_ptr[i], m_vld[i], m_ptr[i]);
        end
        if (m_vld[i]) begin
          checks++;
          if (obs_idx[i] !== m_idx[i] || obs_oh[i] !== m_oh[i] || obs_mul[i] !== m_mul[i]) begin
            failures++;
            $display("FAIL rand_result inst=%0d cyc=%0d got idx=%0d oh=%h m=%b exp idx=%0d oh=%h m=%b",
                     i, cyc, obs_idx[i], obs_oh[i], obs_mul[i], m_idx[i], m_oh[i], m_mul[i]);
          end
        end
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    step();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_req    = '0;
    out_ready = 1'b1;
    #12;
    test_reset();
    test_walking_one();
    test_multi_and_zero();
    test_rr_sequence();
    test_backpressure();
    test_rr_n5_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
